clkdiv_ctrl: RTL and testbench
==============================

// Module: clkdiv_ctrl
// PURPOSE
//  Run-time programmable, glitch-free clock divider controller. Produces clk_o and a
//  one-cycle tick from clk_i, using posedge logic only. Divide ratio is loaded through a
//  valid/ready handshake and only swaps at a period boundary. run gates the output and
//  stops it cleanly. Sits between the host config path and the 16 MHz target clock.
// PARAMETERS
//  CNT_W        8   width of divide ratio and period counter
//  DEFAULT_DIV  3   ratio loaded at reset (48 MHz -> 16 MHz); must be >= 2
// PORTS
//  clk_i      in   1      system clock (48 MHz)
//  rst_n      in   1      asynchronous reset, active-low
//  run        in   1      1 = generate clk_o; 0 = stop at next period boundary
//  cfg_valid  in   1      new ratio offered
//  cfg_div    in   CNT_W  requested ratio N, in clk_i cycles per clk_o period
//  cfg_ready  out  1      controller can accept a ratio
//  cfg_err    out  1      one-cycle pulse: accepted ratio was < 2 and was discarded
//  busy       out  1      an accepted ratio is pending, not yet applied
//  clk_o      out  1      divided clock, registered
//  tick       out  1      one-cycle pulse on the first high cycle of each clk_o period
// BEHAVIOUR
//  Reset (async, while rst_n=0): state=IDLE, div=DEFAULT_DIV, cnt=0, clk_o=0, tick=0,
//   cfg_ready=1, cfg_err=0, busy=0, pending cleared. Reset mid-period drops clk_o at once.
//  Period: cnt runs 0..div-1. HI = div>>1. clk_o=1 while cnt<HI, else 0.
//   N=3 gives 1 high, 2 low; N=4 gives 2/2. tick=1 iff cnt==0 in RUN/PEND.
//  Boundary: a cycle with cnt==div-1.
//  States:
//   IDLE: clk_o=0, cnt=0. run=1 -> RUN; clk_o and tick are high the next cycle
//         (1-cycle start latency).
//   RUN:  cnt advances each cycle. Handshake accept -> PEND.
//         run=0 at a boundary -> IDLE; clk_o stays 0 after that boundary.
//   PEND: same as RUN, with a new ratio held. At the next boundary, div<=pending and
//         cnt<=0 -> RUN; if run=0 at that boundary -> IDLE, still loading div.
//  Handshake: accept = cfg_valid & cfg_ready. cfg_ready = !busy. busy=1 only in PEND.
//   An accept in IDLE loads div directly on the next cycle (no PEND).
//   An accept on a boundary cycle is applied at the following boundary, never the
//   current one.
//  Invalid ratio (cfg_div<2): still accepted (ready stays high). cfg_err pulses the
//   next cycle. div and state are unchanged.
//  run toggling mid-period has no effect until the boundary. run 0->1 in the same cycle
//   as the boundary keeps RUN with no gap.
//  No dual-edge logic. clk_o is never a combinational output. High and low phases are
//   never shorter than 1 clk_i cycle.
// STRUCTURE
//  Package clkdiv_pkg holds:
//   - state enum {IDLE, RUN, PEND}
//   - MIN_DIV = 2
//   - DEFAULT_DIV default
//  One sub-module, clkdiv_counter: the period counter plus HI compare, with load/clear
//   inputs and boundary/clk_o/tick outputs. clkdiv_ctrl holds the FSM, handshake and
//   pending register.
// TESTING
//  1 Reset, run=1 with default N=3 -> clk_o = 1,0,0 repeating. tick every 3rd cycle.
//    First high cycle is 1 cycle after run rises.
//  2 Mid-period, offer cfg_div=4 -> busy=1, cfg_ready=0 until the boundary.
//    Next period is 1,1,0,0. The old period is never truncated.
//  3 Offer cfg_div=1, then cfg_div=0 -> cfg_err pulses each time. Waveform stays N=3.
//    busy stays 0.
//  4 Drop run mid-high-phase at N=8 -> period completes (4 high, 4 low), then clk_o=0.
//    Re-raise run -> restart with tick.
//  5 Accept exactly on a boundary cycle -> new N takes effect one full period later.
//    Accept in IDLE -> first period after run uses new N.
//  6 Assert rst_n=0 asynchronously mid-high-phase -> clk_o=0 immediately, div=3,
//    pending cleared. No tick until run again.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the programmable clock divider controller.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    // Smallest ratio that still gives at least one high and one low cycle.
    localparam int MIN_DIV       = 2;
    localparam int DIV_DEFAULT   = 3;
    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/clkdiv_counter.sv
// Period counter with high-phase compare; clk_o and tick are registered from next-state values.
module clkdiv_counter
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             adv_i,
    input  logic             en_next_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_div_i,
    output logic             boundary_o,
    output logic             clk_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    always_comb begin
        boundary_o = adv_i && (cnt_q == (div_q - CNT_W'(1)));
        cnt_d      = (adv_i && !boundary_o) ? (cnt_q + CNT_W'(1)) : '0;
        div_d      = load_i ? load_div_i : div_q;
        // Outputs are decoded from the values the counter will hold next cycle,
        // so the registered clk_o/tick line up with the count they describe.
        clk_d      = en_next_i && (cnt_d < (div_d >> 1));
        tick_d     = en_next_i && (cnt_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= CNT_W'(DEFAULT_DIV);
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/clkdiv_ctrl.sv
// Glitch-free programmable clock divider: run/stop FSM, ratio handshake and pending ratio.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             busy,
    output logic             clk_o,
    output logic             tick
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             err_q, err_d;
    logic             load;
    logic [CNT_W-1:0] load_div;
    logic             boundary;
    logic             accept;
    logic             div_ok;

    function automatic logic div_valid(input logic [CNT_W-1:0] d);
        return d >= CNT_W'(MIN_DIV);
    endfunction

    assign busy      = (state_q == PEND);
    assign cfg_ready = !busy;
    assign accept    = cfg_valid && cfg_ready;
    assign div_ok    = div_valid(cfg_div);
    assign cfg_err   = err_q;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        err_d    = accept && !div_ok;
        load     = 1'b0;
        load_div = pend_q;
        case (state_q)
            IDLE: begin
                if (accept && div_ok) begin
                    load     = 1'b1;
                    load_div = cfg_div;
                end
                if (run) state_d = RUN;
            end
            RUN: begin
                if (boundary && !run) begin
                    // Stopping here: no period is left to protect, so load immediately.
                    state_d = IDLE;
                    if (accept && div_ok) begin
                        load     = 1'b1;
                        load_div = cfg_div;
                    end
                end else if (accept && div_ok) begin
                    state_d = PEND;
                    pend_d  = cfg_div;
                end
            end
            PEND: begin
                if (boundary) begin
                    load     = 1'b1;
                    load_div = pend_q;
                    state_d  = run ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    clkdiv_counter #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_counter (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .adv_i      (state_q != IDLE),
        .en_next_i  (state_d != IDLE),
        .load_i     (load),
        .load_div_i (load_div),
        .boundary_o (boundary),
        .clk_o      (clk_o),
        .tick_o     (tick)
    );

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl with hand-computed waveforms per step.
module tb_clkdiv_ctrl;

    logic       clk_i;
    logic       rst_n;
    logic       run;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       busy;
    logic       clk_o;
    logic       tick;

    int n_checks = 0;
    int n_err    = 0;

    clkdiv_ctrl dut (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .busy      (busy),
        .clk_o     (clk_o),
        .tick      (tick)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic c, input logic t);
        step();
        chk({tag, ".clk_o"}, {7'd0, clk_o}, {7'd0, c});
        chk({tag, ".tick"},  {7'd0, tick},  {7'd0, t});
    endtask

    task automatic offer(input logic [7:0] d);
        cfg_valid = 1'b1;
        cfg_div   = d;
        $display("t=%0t cfg offer div=%0d ready=%0b", $time, d, cfg_ready);
    endtask

    initial begin
        rst_n     = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;

        // Reset state
        step();
        step();
        chk("rst.clk_o", {7'd0, clk_o}, 8'd0);
        chk("rst.tick", {7'd0, tick}, 8'd0);
        chk("rst.ready", {7'd0, cfg_ready}, 8'd1);
        chk("rst.busy", {7'd0, busy}, 8'd0);
        chk("rst.err", {7'd0, cfg_err}, 8'd0);
        rst_n = 1'b1;
        run   = 1'b1;

        // Default N=3: 1,0,0 with tick on the high cycle, one cycle after run
        for (int i = 0; i < 3; i++) begin
            step_chk("n3.c0", 1'b1, 1'b1);
            step_chk("n3.c1", 1'b0, 1'b0);
            step_chk("n3.c2", 1'b0, 1'b0);
        end
        step_chk("n3.c0b", 1'b1, 1'b1);

        // Mid-period offer of N=4: old period completes, then 1,1,0,0
        offer(8'd4);
        step_chk("n4.old1", 1'b0, 1'b0);
        chk("n4.busy1", {7'd0, busy}, 8'd1);
        chk("n4.ready1", {7'd0, cfg_ready}, 8'd0);
        cfg_valid = 1'b0;
        step_chk("n4.old2", 1'b0, 1'b0);
        chk("n4.busy2", {7'd0, busy}, 8'd1);
        chk("n4.ready2", {7'd0, cfg_ready}, 8'd0);
        step_chk("n4.c0", 1'b1, 1'b1);
        chk("n4.busy3", {7'd0, busy}, 8'd0);
        chk("n4.ready3", {7'd0, cfg_ready}, 8'd1);
        step_chk("n4.c1", 1'b1, 1'b0);
        step_chk("n4.c2", 1'b0, 1'b0);
        step_chk("n4.c3", 1'b0, 1'b0);
        step_chk("n4.c0b", 1'b1, 1'b1);

        // Back to N=3, then invalid ratios 1 and 0
        offer(8'd3);
        step_chk("to3.c1", 1'b1, 1'b0);
        chk("to3.busy", {7'd0, busy}, 8'd1);
        cfg_valid = 1'b0;
        step_chk("to3.c2", 1'b0, 1'b0);
        step_chk("to3.c3", 1'b0, 1'b0);
        step_chk("to3.c0", 1'b1, 1'b1);
        offer(8'd1);
        step_chk("inv1.c1", 1'b0, 1'b0);
        chk("inv1.err", {7'd0, cfg_err}, 8'd1);
        chk("inv1.busy", {7'd0, busy}, 8'd0);
        offer(8'd0);
        step_chk("inv0.c2", 1'b0, 1'b0);
        chk("inv0.err", {7'd0, cfg_err}, 8'd1);
        chk("inv0.busy", {7'd0, busy}, 8'd0);
        cfg_valid = 1'b0;
        step_chk("inv.c0", 1'b1, 1'b1);
        chk("inv.err_clr", {7'd0, cfg_err}, 8'd0);
        step_chk("inv.c1", 1'b0, 1'b0);
        step_chk("inv.c2", 1'b0, 1'b0);
        step_chk("inv.c0b", 1'b1, 1'b1);

        // N=8, drop run mid-high-phase: full 4/4 period then idle
        offer(8'd8);
        step_chk("to8.c1", 1'b0, 1'b0);
        cfg_valid = 1'b0;
        step_chk("to8.c2", 1'b0, 1'b0);
        step_chk("n8.c0", 1'b1, 1'b1);
        step_chk("n8.c1", 1'b1, 1'b0);
        run = 1'b0;
        step_chk("n8.c2", 1'b1, 1'b0);
        step_chk("n8.c3", 1'b1, 1'b0);
        for (int i = 4; i < 8; i++) step_chk("n8.lo", 1'b0, 1'b0);
        step_chk("n8.idle1", 1'b0, 1'b0);
        step_chk("n8.idle2", 1'b0, 1'b0);
        run = 1'b1;
        step_chk("n8.restart", 1'b1, 1'b1);
        step_chk("n8.r1", 1'b1, 1'b0);

        // Accept exactly on a boundary: one more full N=8 period first
        for (int i = 2; i < 4; i++) step_chk("bnd.hi", 1'b1, 1'b0);
        for (int i = 4; i < 8; i++) step_chk("bnd.lo", 1'b0, 1'b0);
        offer(8'd4);
        step_chk("bnd.p0", 1'b1, 1'b1);
        chk("bnd.busy", {7'd0, busy}, 8'd1);
        cfg_valid = 1'b0;
        for (int i = 1; i < 4; i++) step_chk("bnd.phi", 1'b1, 1'b0);
        for (int i = 4; i < 8; i++) step_chk("bnd.plo", 1'b0, 1'b0);
        chk("bnd.busy_end", {7'd0, busy}, 8'd1);
        step_chk("bnd.n4c0", 1'b1, 1'b1);
        chk("bnd.busy_clr", {7'd0, busy}, 8'd0);
        step_chk("bnd.n4c1", 1'b1, 1'b0);
        step_chk("bnd.n4c2", 1'b0, 1'b0);
        step_chk("bnd.n4c3", 1'b0, 1'b0);
        run = 1'b0;
        step_chk("idl.stop", 1'b0, 1'b0);

        // Accept in IDLE: first period after run uses N=6 (3 high, 3 low)
        offer(8'd6);
        step_chk("idl.acc", 1'b0, 1'b0);
        chk("idl.busy", {7'd0, busy}, 8'd0);
        chk("idl.ready", {7'd0, cfg_ready}, 8'd1);
        cfg_valid = 1'b0;
        run       = 1'b1;
        step_chk("n6.c0", 1'b1, 1'b1);
        step_chk("n6.c1", 1'b1, 1'b0);
        step_chk("n6.c2", 1'b1, 1'b0);
        step_chk("n6.c3", 1'b0, 1'b0);
        step_chk("n6.c4", 1'b0, 1'b0);
        step_chk("n6.c5", 1'b0, 1'b0);
        step_chk("n6.c0b", 1'b1, 1'b1);

        // Asynchronous reset mid-high-phase with a ratio pending
        step_chk("ar.c1", 1'b1, 1'b0);
        offer(8'd5);
        step_chk("ar.c2", 1'b1, 1'b0);
        chk("ar.busy_pre", {7'd0, busy}, 8'd1);
        cfg_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.clk_o", {7'd0, clk_o}, 8'd0);
        chk("ar.tick", {7'd0, tick}, 8'd0);
        chk("ar.busy", {7'd0, busy}, 8'd0);
        chk("ar.ready", {7'd0, cfg_ready}, 8'd1);
        run = 1'b0;
        step_chk("ar.hold", 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step_chk("ar.quiet", 1'b0, 1'b0);
        run = 1'b1;
        step_chk("ar.n3c0", 1'b1, 1'b1);
        step_chk("ar.n3c1", 1'b0, 1'b0);
        step_chk("ar.n3c2", 1'b0, 1'b0);
        step_chk("ar.n3c0b", 1'b1, 1'b1);
        chk("ar.busy_post", {7'd0, busy}, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
